// File: rtl/dot_controller.sv
// Maze dot/pellet map owner: reloads the map, serves eat requests, keeps score and dots left,
// and answers the renderer's per-pixel lookup. Optional frightened timer: FRIGHT_TIMER_EN.
`timescale 1ns/1ps
module dot_controller #(
  parameter int unsigned ROWS          = 31,
  parameter int unsigned COLS          = 28,
  parameter int unsigned DOT_PTS       = 10,
  parameter int unsigned PELLET_PTS    = 50,
  parameter int unsigned FRIGHT_FRAMES = 360
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        level_restart,
  input  logic        eat_req,
  input  logic [4:0]  pac_row,
  input  logic [4:0]  pac_col,
  output logic        eat_ack,
  output logic        dot_eaten,
  output logic        pellet_eaten,
  output logic        busy,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        is_point,
  output logic        is_pellet,
  output logic [15:0] score,
  output logic [8:0]  dots_left,
  output logic        level_clear,
  output logic        fright_active
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 9;
  localparam int unsigned SW = 16;
  localparam int unsigned FW = $clog2(FRIGHT_FRAMES + 1);
  localparam int unsigned TILE = 12;
  localparam int unsigned ORG  = 72;

  typedef enum logic [1:0] {RELOAD, IDLE, CHECK, CLEAR} state_t;

  // Constant maze image: bit c of a row is column c.
  function automatic logic [COLS-1:0] maze_point(input logic [RW-1:0] r);
    case (r)
      5'd0, 5'd30:       maze_point = '0;
      5'd1, 5'd5, 5'd29: maze_point = COLS'(28'h7FF_FFFE);
      5'd3:              maze_point = COLS'(28'h020_0040);
      5'd23:             maze_point = COLS'(28'h420_0040);
      default:           maze_point = COLS'(28'h420_0042);
    endcase
  endfunction

  function automatic logic [COLS-1:0] maze_pellet(input logic [RW-1:0] r);
    case (r)
      5'd3, 5'd23: maze_pellet = COLS'(28'h400_0002);
      default:     maze_pellet = '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] popcnt(input logic [COLS-1:0] v);
    popcnt = '0;
    for (int i = 0; i < int'(COLS); i++) popcnt = popcnt + DW'(v[i]);
  endfunction

  state_t          state_q;
  logic [RW-1:0]   row_idx_q, tr_q, tc_q;
  logic [COLS-1:0] point_q  [ROWS];
  logic [COLS-1:0] pellet_q [ROWS];
  logic [SW-1:0]   score_q;
  logic [DW-1:0]   dots_q;
  logic            ack_q, dot_q, pel_q, busy_q, clear_q, pend_q;
  logic            is_point_q, is_pellet_q;

  logic [DW-1:0]   row_cnt_c;
  logic            in_range_c, tile_pt_c, tile_pel_c;
  logic [SW:0]     score_sum_c;

  always_comb begin
    row_cnt_c   = popcnt(maze_point(row_idx_q) | maze_pellet(row_idx_q));
    in_range_c  = (tr_q < RW'(ROWS)) && (tc_q < RW'(COLS));
    tile_pt_c   = in_range_c && point_q[tr_q][tc_q];
    tile_pel_c  = in_range_c && pellet_q[tr_q][tc_q];
    score_sum_c = {1'b0, score_q} + (SW+1)'(tile_pel_c ? PELLET_PTS : DOT_PTS);
  end

  // Main sequencer; busy/level_clear are registered from the state being entered.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= RELOAD;
      row_idx_q <= '0;
      tr_q      <= '0;
      tc_q      <= '0;
      score_q   <= '0;
      dots_q    <= '0;
      ack_q     <= 1'b0;
      dot_q     <= 1'b0;
      pel_q     <= 1'b0;
      busy_q    <= 1'b1;
      clear_q   <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      dot_q   <= 1'b0;
      pel_q   <= 1'b0;
      clear_q <= 1'b0;
      case (state_q)
        RELOAD: begin
          point_q[row_idx_q]  <= maze_point(row_idx_q);
          pellet_q[row_idx_q] <= maze_pellet(row_idx_q);
          dots_q              <= dots_q + row_cnt_c;
          if (row_idx_q == RW'(ROWS - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            clear_q <= ((dots_q + row_cnt_c) == '0);
          end else begin
            row_idx_q <= row_idx_q + 1'b1;
          end
        end
        IDLE: begin
          if (level_restart || pend_q) begin
            state_q   <= RELOAD;
            row_idx_q <= '0;
            dots_q    <= '0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b1;
          end else if (eat_req) begin
            state_q <= CHECK;
            tr_q    <= pac_row;
            tc_q    <= pac_col;
            busy_q  <= 1'b1;
          end else begin
            clear_q <= (dots_q == '0);
          end
        end
        CHECK: begin
          if (level_restart) pend_q <= 1'b1;
          if (tile_pel_c || tile_pt_c) begin
            state_q <= CLEAR;
          end else begin
            state_q <= IDLE;
            ack_q   <= 1'b1;
            busy_q  <= 1'b0;
            clear_q <= (dots_q == '0);
          end
        end
        CLEAR: begin
          if (level_restart) pend_q <= 1'b1;
          point_q[tr_q][tc_q]  <= 1'b0;
          pellet_q[tr_q][tc_q] <= 1'b0;
          dots_q   <= dots_q - 1'b1;
          score_q  <= score_sum_c[SW] ? '1 : score_sum_c[SW-1:0];
          ack_q    <= 1'b1;
          pel_q    <= tile_pel_c;
          dot_q    <= !tile_pel_c;
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          clear_q  <= (dots_q == DW'(1));
        end
        default: state_q <= RELOAD;
      endcase
    end
  end

  logic [9:0]    x_off_c, y_off_c;
  logic [RW-1:0] rd_row_c, rd_col_c;
  logic          rd_ok_c, is_point_d, is_pellet_d;

  // Pixel-to-tile lookup; rows not yet rewritten during a reload are masked off.
  always_comb begin
    x_off_c  = DrawX - 10'(ORG);
    y_off_c  = DrawY - 10'(ORG);
    rd_row_c = RW'(y_off_c / 10'(TILE));
    rd_col_c = RW'(x_off_c / 10'(TILE));
    rd_ok_c  = (DrawX >= 10'(ORG)) && (DrawX < 10'(ORG + COLS * TILE)) &&
               (DrawY >= 10'(ORG)) && (DrawY < 10'(ORG + ROWS * TILE)) &&
               ((state_q != RELOAD) || (rd_row_c < row_idx_q));
    is_point_d  = rd_ok_c && point_q[rd_row_c][rd_col_c];
    is_pellet_d = rd_ok_c && pellet_q[rd_row_c][rd_col_c];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      is_point_q  <= 1'b0;
      is_pellet_q <= 1'b0;
    end else begin
      is_point_q  <= is_point_d;
      is_pellet_q <= is_pellet_d;
    end
  end

`ifdef FRIGHT_TIMER_EN
  logic [FW-1:0] fright_cnt_q;
  logic          fright_q;
  logic          fright_load_c, fright_clr_c;

  assign fright_load_c = (state_q == CLEAR) && tile_pel_c;
  assign fright_clr_c  = (state_q == IDLE) && (level_restart || pend_q);

  // Frightened countdown in frames; a fresh pellet restarts the full period.
  always_ff @(posedge Clk) begin
    if (!Reset_n || fright_clr_c) begin
      fright_cnt_q <= '0;
      fright_q     <= 1'b0;
    end else if (fright_load_c) begin
      fright_cnt_q <= FW'(FRIGHT_FRAMES);
      fright_q     <= 1'b1;
    end else if (frame_tick && (fright_cnt_q != '0)) begin
      fright_cnt_q <= fright_cnt_q - 1'b1;
      fright_q     <= (fright_cnt_q != FW'(1));
    end
  end

  assign fright_active = fright_q;
`else
  logic [FW-1:0] unused_fright_c;
  assign unused_fright_c = FW'(FRIGHT_FRAMES) ^ {FW{frame_tick}};
  assign fright_active   = 1'b0;
`endif

  assign eat_ack      = ack_q;
  assign dot_eaten    = dot_q;
  assign pellet_eaten = pel_q;
  assign busy         = busy_q;
  assign is_point     = is_point_q;
  assign is_pellet    = is_pellet_q;
  assign score        = score_q;
  assign dots_left    = dots_q;
  assign level_clear  = clear_q;

endmodule
